// File: rtl/neopixel_rx_pkg.sv
// Shared WS2812 definitions for the neopixel receiver: transmitter bit timings at 16 MHz
// and the receiver state encodings.
package neopixel_rx_pkg;

  localparam int T0H           = 6;
  localparam int T1H           = 13;
  localparam int TF            = 20;
  localparam int T_RESET_16MHZ = 800;

  typedef enum logic [2:0] {
    ST_WAIT_RESET = 3'd0,
    ST_IDLE       = 3'd1,
    ST_HIGH       = 3'd2,
    ST_LOW        = 3'd3,
    ST_PASS       = 3'd4
  } rx_state_e;

endpackage

// File: rtl/neopixel_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 data line; resets to 0.
module neopixel_sync (
  input  logic clk_16MHz,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receiver: decodes the first nbr_pixels*24 bits of a frame by high-pulse width,
// forwards later bits on dout, and latches the frame on the low reset gap.
//
//  state         | meaning
//  --------------+-----------------------------------------------------------
//  ST_WAIT_RESET | ignore the line until T_RESET consecutive low cycles
//  ST_IDLE       | between frames, waiting for the first rising edge
//  ST_HIGH       | measuring the high part of a captured bit
//  ST_LOW        | low part of a captured bit, waiting for next rise
//  ST_PASS       | frame captured, forwarding the line to dout until reset gap
module neopixel_rx
  import neopixel_rx_pkg::*;
#(
  parameter int nbr_pixels   = 1,
  parameter int T_BIT_THRESH = (T0H + T1H + 1) / 2,
  parameter int T_HIGH_MAX   = 32,
  parameter int T_RESET      = T_RESET_16MHZ
) (
  input  logic                       clk_16MHz,
  input  logic                       rst,
  input  logic                       din,
  output logic                       dout,
  output logic [nbr_pixels*24-1:0]   data_out,
  output logic                       data_valid,
  output logic                       rx_error,
  output logic                       busy
);

  localparam int NBITS = nbr_pixels * 24;
  // hcnt must be able to exceed T_HIGH_MAX by one to flag a malformed pulse
  localparam int HW = $clog2(T_HIGH_MAX + 2);
  localparam int LW = $clog2(T_RESET + 1);
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [HW-1:0] HCNT_SAT = HW'(T_HIGH_MAX + 1);
  localparam logic [HW-1:0] HCNT_LIM = HW'(T_HIGH_MAX);
  localparam logic [HW-1:0] HCNT_THR = HW'(T_BIT_THRESH);
  localparam logic [LW-1:0] LCNT_SAT = LW'(T_RESET);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  rx_state_e        state, state_nxt;
  logic             din_s;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic [LW-1:0]    lcnt, lcnt_nxt;
  logic [BW-1:0]    bitcnt;
  logic [NBITS-1:0] shreg;
  logic             lcnt_reach;
  logic             start, shift_en, err, latch, fwd;

  neopixel_sync u_sync (
    .clk_16MHz (clk_16MHz),
    .rst       (rst),
    .d         (din),
    .q         (din_s)
  );

  always_comb begin
    hcnt_nxt = '0;
    lcnt_nxt = '0;
    if (din_s) hcnt_nxt = (hcnt == HCNT_SAT) ? hcnt : hcnt + 1'b1;
    else       lcnt_nxt = (lcnt == LCNT_SAT) ? lcnt : lcnt + 1'b1;
  end

  // A rise forces lcnt_nxt to 0, so a rise always wins over the reset gap
  assign lcnt_reach = (lcnt_nxt == LCNT_SAT);

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) state <= ST_WAIT_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT_RESET: if (lcnt_reach) state_nxt = ST_IDLE;
      ST_IDLE:       if (din_s) state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (din_s) begin
          if (hcnt_nxt > HCNT_LIM) state_nxt = ST_WAIT_RESET;
        end else if (bitcnt == BIT_LAST) begin
          state_nxt = ST_PASS;
        end else begin
          state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (din_s)           state_nxt = ST_HIGH;
        else if (lcnt_reach) state_nxt = ST_IDLE;
      end
      ST_PASS:       if (lcnt_reach) state_nxt = ST_IDLE;
      default:       state_nxt = ST_WAIT_RESET;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    shift_en = 1'b0;
    err      = 1'b0;
    latch    = 1'b0;
    fwd      = 1'b0;
    busy     = 1'b0;
    unique case (state)
      ST_IDLE: start = din_s;
      ST_HIGH: begin
        busy     = 1'b1;
        shift_en = !din_s;
        err      = din_s && (hcnt_nxt > HCNT_LIM);
      end
      ST_LOW: begin
        busy = 1'b1;
        err  = lcnt_reach;
      end
      ST_PASS: begin
        busy  = 1'b1;
        latch = lcnt_reach;
        fwd   = !lcnt_reach;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) begin
      hcnt       <= '0;
      lcnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      rx_error   <= 1'b0;
      dout       <= 1'b0;
    end else begin
      hcnt       <= hcnt_nxt;
      lcnt       <= lcnt_nxt;
      data_valid <= latch;
      rx_error   <= err;
      dout       <= fwd & din_s;
      if (start) begin
        bitcnt <= '0;
        shreg  <= '0;
      end else if (shift_en) begin
        shreg  <= {shreg[NBITS-2:0], (hcnt >= HCNT_THR)};
        bitcnt <= bitcnt + 1'b1;
      end
      if (latch) data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives transmitter-shaped bit waveforms and checks
// captured frames through a scoreboard queue, plus error, busy and forwarding behaviour.
`timescale 1ns/1ps
module tb_neopixel_rx;
  import neopixel_rx_pkg::*;

  logic        clk_16MHz = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] data_out;
  logic        data_valid;
  logic        rx_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic        fwd = 1'b0;
  logic [2:0]  din_hist = '0;
  logic [2:0]  fwd_hist = '0;
  int          dv_cnt = 0, err_cnt = 0, dout_hi = 0, dout_bad = 0;
  int          exp_dout_hi = 0;

  neopixel_rx dut (
    .clk_16MHz  (clk_16MHz),
    .rst        (rst),
    .din        (din),
    .dout       (dout),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rx_error   (rx_error),
    .busy       (busy)
  );

  always #31.25 clk_16MHz = ~clk_16MHz;

  always @(posedge clk_16MHz) begin
    din_hist <= {din_hist[1:0], din};
    fwd_hist <= {fwd_hist[1:0], fwd};
  end

  // Scoreboard side: every data_valid pops one expected frame
  always @(negedge clk_16MHz) begin
    logic [23:0] exp_v;
    if (data_valid) begin
      dv_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL dv_unexpected: observed data_out %06h, expected no frame", data_out);
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert (data_out === exp_v) else begin
          errors++;
          $error("FAIL frame: observed %06h expected %06h", data_out, exp_v);
        end
      end
    end
    if (rx_error) err_cnt++;
    if (dout === 1'b1) dout_hi++;
    if (dout !== (fwd_hist[2] & din_hist[2])) dout_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_16MHz);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] val, input int n, input int hi1, input int lo1,
                           input int hi0, input int lo0, input bit fw);
    for (int i = 23; i > 23 - n; i--) begin
      fwd = fw;
      din = 1'b1;
      step(val[i] ? hi1 : hi0);
      din = 1'b0;
      step(val[i] ? lo1 : lo0);
      if (fw) exp_dout_hi += val[i] ? hi1 : hi0;
    end
    fwd = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] val, input bit fw);
    send_bits(val, 24, T1H + 1, TF - T1H, T0H + 1, TF - T0H, fw);
  endtask

  initial begin
    int dv0, err0, bad0;
    logic [23:0] last_frame;

    // reset state
    step(3);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_error", 32'(rx_error), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step(900);

    // single clean frame
    dv0 = dv_cnt; err0 = err_cnt; bad0 = dout_bad;
    exp_q.push_back(24'hA5C3F0);
    send_frame(24'hA5C3F0, 1'b0);
    chk("f1_busy", 32'(busy), 1);
    step(900);
    chk("f1_data", 32'(data_out), 32'h00A5C3F0);
    chk("f1_dv_pulses", dv_cnt - dv0, 1);
    chk("f1_errors", err_cnt - err0, 0);
    chk("f1_dout_zero", dout_bad - bad0, 0);
    chk("f1_busy_end", 32'(busy), 0);
    chk("f1_queue", exp_q.size(), 0);

    // capture 24 bits, forward the next 24
    dv0 = dv_cnt; err0 = err_cnt; bad0 = dout_bad;
    exp_q.push_back(24'h123456);
    send_frame(24'h123456, 1'b0);
    chk("f2_busy_pass", 32'(busy), 1);
    exp_dout_hi = 0;
    begin
      int hi0 = dout_hi;
      send_frame(24'hABCDEF, 1'b1);
      step(900);
      chk("f2_dout_width", dout_hi - hi0, exp_dout_hi);
    end
    chk("f2_data", 32'(data_out), 32'h00123456);
    chk("f2_dv_pulses", dv_cnt - dv0, 1);
    chk("f2_errors", err_cnt - err0, 0);
    chk("f2_dout_lag", dout_bad - bad0, 0);
    chk("f2_queue", exp_q.size(), 0);

    // threshold: 10-cycle high decodes as 1, 9-cycle high as 0
    dv0 = dv_cnt; err0 = err_cnt;
    exp_q.push_back(24'h5A0F3C);
    send_bits(24'h5A0F3C, 24, 10, 11, 9, 12, 1'b0);
    step(900);
    chk("thr_data", 32'(data_out), 32'h005A0F3C);
    chk("thr_dv_pulses", dv_cnt - dv0, 1);
    chk("thr_errors", err_cnt - err0, 0);

    // malformed 40-cycle high mid-frame
    dv0 = dv_cnt; err0 = err_cnt;
    send_bits(24'hF0F0F0, 5, 14, 7, 7, 14, 1'b0);
    din = 1'b1;
    step(38);
    chk("long_err_pulse", err_cnt - err0, 1);
    chk("long_busy", 32'(busy), 0);
    step(2);
    din = 1'b0;
    step(100);
    send_frame(24'h00FF00, 1'b0);
    step(900);
    chk("long_ignored_dv", dv_cnt - dv0, 0);
    chk("long_err_total", err_cnt - err0, 1);
    chk("long_data_kept", 32'(data_out), 32'h005A0F3C);
    exp_q.push_back(24'h3C5A96);
    send_frame(24'h3C5A96, 1'b0);
    step(900);
    chk("long_recover", 32'(data_out), 32'h003C5A96);
    chk("long_recover_dv", dv_cnt - dv0, 1);
    last_frame = 24'h3C5A96;

    // short frame: 12 bits then reset gap
    dv0 = dv_cnt; err0 = err_cnt;
    send_bits(24'hFFF000, 12, 14, 7, 7, 14, 1'b0);
    step(900);
    chk("short_err", err_cnt - err0, 1);
    chk("short_dv", dv_cnt - dv0, 0);
    chk("short_data_kept", 32'(data_out), 32'(last_frame));
    chk("short_busy", 32'(busy), 0);

    // reset during bit 10
    dv0 = dv_cnt; err0 = err_cnt;
    send_bits(24'hAAAAAA, 9, 14, 7, 7, 14, 1'b0);
    din = 1'b1;
    step(5);
    rst = 1'b1;
    step(2);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_data", 32'(data_out), 0);
    chk("mid_rst_valid", 32'(data_valid), 0);
    chk("mid_rst_error", 32'(rx_error), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    din = 1'b0;
    step(3);
    rst = 1'b0;
    step(900);
    exp_q.push_back(24'hC0FFEE);
    send_frame(24'hC0FFEE, 1'b0);
    step(900);
    chk("mid_rst_frame", 32'(data_out), 32'h00C0FFEE);
    chk("mid_rst_dv", dv_cnt - dv0, 1);
    chk("mid_rst_errors", err_cnt - err0, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
